// File: rtl/maindec_pipe.sv
// MIPS main decoder: combinational opcode/funct decode feeding PIPE_DEPTH valid/ready
// register stages with flush. Optional illegal-opcode counter under `DEC_ILLEGAL_CNT_EN`.
module maindec_pipe #(
    parameter int CTRL_W     = 11,
    parameter int PIPE_DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_illegal
`ifdef DEC_ILLEGAL_CNT_EN
    ,
    output logic [15:0]       illegal_cnt
`endif
);

    localparam int LAST = PIPE_DEPTH - 1;

    logic [10:0] dec_ctrl;
    logic        dec_illegal;
    logic        accept;

    logic [PIPE_DEPTH-1:0] vld_q, vld_d;
    logic [PIPE_DEPTH-1:0] ill_q, ill_d;
    logic [10:0]           ctrl_q [PIPE_DEPTH];
    logic [10:0]           ctrl_d [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] load;

    // Control bits, LSB first: Jump MemtoReg MemWrite Branch AluSrc RegDst
    // RegWrite Link ZeroExt MemRead JumpReg.
    always_comb begin
        dec_ctrl    = 11'h000;
        dec_illegal = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b001000: dec_ctrl = 11'h401;
                    6'b001001: dec_ctrl = 11'h4E1;
                    default:   dec_ctrl = 11'h060;
                endcase
            end
            6'b100011: dec_ctrl = 11'h252;
            6'b101011: dec_ctrl = 11'h014;
            6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: dec_ctrl = 11'h008;
            6'b001000, 6'b001001, 6'b001010, 6'b001011: dec_ctrl = 11'h050;
            6'b001100, 6'b001101, 6'b001110, 6'b001111: dec_ctrl = 11'h150;
            6'b000010: dec_ctrl = 11'h001;
            6'b000011: dec_ctrl = 11'h0C1;
            default:   dec_illegal = 1'b1;
        endcase
    end

    // A stage may load when empty or when its own contents move on; this
    // ripples combinationally from out_ready back to in_ready.
    always_comb begin
        load       = '0;
        load[LAST] = !vld_q[LAST] || out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            load[k] = !vld_q[k] || load[k+1];
        end
    end

    assign in_ready = load[0];
    assign accept   = in_valid && in_ready && !flush;

    // Empty stages always hold zero data, so shifting an empty stage forward clears the next.
    always_comb begin
        vld_d  = vld_q;
        ill_d  = ill_q;
        ctrl_d = ctrl_q;
        if (flush) begin
            vld_d = '0;
            ill_d = '0;
            for (int k = 0; k < PIPE_DEPTH; k++) ctrl_d[k] = 11'h000;
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                if (load[k]) begin
                    if (k == 0) begin
                        vld_d[0]  = accept;
                        ill_d[0]  = accept && dec_illegal;
                        ctrl_d[0] = accept ? dec_ctrl : 11'h000;
                    end else begin
                        vld_d[k]  = vld_q[k-1];
                        ill_d[k]  = ill_q[k-1];
                        ctrl_d[k] = ctrl_q[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            ill_q <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) ctrl_q[k] <= 11'h000;
        end else begin
            vld_q <= vld_d;
            ill_q <= ill_d;
            for (int k = 0; k < PIPE_DEPTH; k++) ctrl_q[k] <= ctrl_d[k];
        end
    end

    assign out_valid   = vld_q[LAST];
    assign out_illegal = vld_q[LAST] && ill_q[LAST];
    assign out_ctrl    = vld_q[LAST] ? CTRL_W'(ctrl_q[LAST]) : '0;

`ifdef DEC_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (accept && dec_illegal && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) illegal_cnt_q <= 16'h0000;
        else        illegal_cnt_q <= illegal_cnt_d;
    end

    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_maindec_pipe.sv
// Scoreboard bench for maindec_pipe: a depth-1 and a depth-3 instance share one
// directed stimulus stream; a negedge monitor pops expected {illegal, ctrl} per handshake.
module tb_maindec_pipe;

    localparam int CW = 12;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, out_ready;
    logic [5:0] op, funct;

    logic [1:0]    in_ready_w, out_valid_w, out_ill_w;
    logic [CW-1:0] out_ctrl_w [2];
`ifdef DEC_ILLEGAL_CNT_EN
    logic [15:0]   cnt_w [2];
`endif

    logic [CW:0] exp_cur;
    logic [CW:0] exp_q [2][$];
    logic [CW:0] prev_out [2];
    logic [1:0]  prev_hold;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    maindec_pipe #(.CTRL_W(CW), .PIPE_DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_w[0]), .op(op), .funct(funct),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_ctrl(out_ctrl_w[0]), .out_illegal(out_ill_w[0])
`ifdef DEC_ILLEGAL_CNT_EN
        , .illegal_cnt(cnt_w[0])
`endif
    );

    maindec_pipe #(.CTRL_W(CW), .PIPE_DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_w[1]), .op(op), .funct(funct),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_ctrl(out_ctrl_w[1]), .out_illegal(out_ill_w[1])
`ifdef DEC_ILLEGAL_CNT_EN
        , .illegal_cnt(cnt_w[1])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops on each output handshake, checks gating and stall stability,
    // then records accepts (or discards everything on flush/reset).
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (out_valid_w[i]) begin
                if (out_ready) begin
                    if (exp_q[i].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out[d%0d]: got 0x%0h with empty queue", i * 2 + 1,
                                 {out_ill_w[i], out_ctrl_w[i]});
                    end else begin
                        chk($sformatf("out_word[d%0d]", i * 2 + 1), 32'({out_ill_w[i], out_ctrl_w[i]}),
                            32'(exp_q[i].pop_front()));
                    end
                end
            end else if (out_ctrl_w[i] != '0 || out_ill_w[i]) begin
                chk($sformatf("gating[d%0d]", i * 2 + 1), 32'({out_ill_w[i], out_ctrl_w[i]}), 32'd0);
            end
            if (prev_hold[i]) begin
                chk($sformatf("stall_hold[d%0d]", i * 2 + 1),
                    32'({out_valid_w[i], out_ill_w[i], out_ctrl_w[i]}), 32'({1'b1, prev_out[i]}));
            end
            prev_hold[i] = out_valid_w[i] && !out_ready && rst_n && !flush;
            prev_out[i]  = {out_ill_w[i], out_ctrl_w[i]};
            if (!rst_n || flush) exp_q[i].delete();
            else if (in_valid && in_ready_w[i]) exp_q[i].push_back(exp_cur);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] o, input logic [5:0] f, input logic [10:0] c, input logic ill);
        op       = o;
        funct    = f;
        in_valid = 1'b1;
        exp_cur  = {ill, 1'b0, c};
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    int first_v [2];
    int num_v   [2];

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; funct = '0; exp_cur = '0; prev_hold = '0;
        step(); step();
        chk("reset_valid", 32'(out_valid_w), 32'd0);
        chk("reset_ctrl_d1", 32'(out_ctrl_w[0]), 32'd0);
        chk("reset_ctrl_d3", 32'(out_ctrl_w[1]), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready_w), 32'd3);

        // Back-to-back decode table with out_ready high.
        send(6'b100011, 6'd0,      11'h252, 1'b0); // LW
        send(6'b101011, 6'd0,      11'h014, 1'b0); // SW
        send(6'b000100, 6'd0,      11'h008, 1'b0); // BEQ
        send(6'b001101, 6'd0,      11'h150, 1'b0); // ORI
        send(6'b000011, 6'd0,      11'h0C1, 1'b0); // JAL
        send(6'b000000, 6'b001000, 11'h401, 1'b0); // JR
        send(6'b000000, 6'b001001, 11'h4E1, 1'b0); // JALR
        send(6'b000000, 6'b100000, 11'h060, 1'b0); // ADD
        send(6'b000010, 6'b001001, 11'h001, 1'b0); // J, funct ignored
        send(6'b000101, 6'd0,      11'h008, 1'b0); // BNE
        send(6'b000110, 6'd0,      11'h008, 1'b0); // BLEZ
        send(6'b000111, 6'd0,      11'h008, 1'b0); // BGTZ
        send(6'b000001, 6'd0,      11'h008, 1'b0); // REGIMM
        send(6'b001000, 6'b001000, 11'h050, 1'b0); // ADDI, funct ignored
        send(6'b001001, 6'd0,      11'h050, 1'b0); // ADDIU
        send(6'b001010, 6'd0,      11'h050, 1'b0); // SLTI
        send(6'b001011, 6'd0,      11'h050, 1'b0); // SLTIU
        send(6'b001100, 6'd0,      11'h150, 1'b0); // ANDI
        send(6'b001110, 6'd0,      11'h150, 1'b0); // XORI
        send(6'b001111, 6'd0,      11'h150, 1'b0); // LUI
        send(6'b111111, 6'd0,      11'h000, 1'b1);
        send(6'b111111, 6'b001000, 11'h000, 1'b1);
        send(6'b111111, 6'd0,      11'h000, 1'b1);
        idle(4);
`ifdef DEC_ILLEGAL_CNT_EN
        chk("cnt3_d1", 32'(cnt_w[0]), 32'd3);
        chk("cnt3_d3", 32'(cnt_w[1]), 32'd3);
`endif
        send(6'b010000, 6'd0, 11'h000, 1'b1);
        send(6'b100000, 6'd0, 11'h000, 1'b1);
        idle(4);
`ifdef DEC_ILLEGAL_CNT_EN
        chk("cnt5_d3", 32'(cnt_w[1]), 32'd5);
        force u_d1.illegal_cnt_q = 16'hFFFF;
        force u_d3.illegal_cnt_q = 16'hFFFF;
        step();
        release u_d1.illegal_cnt_q;
        release u_d3.illegal_cnt_q;
        send(6'b111111, 6'd0, 11'h000, 1'b1);
        idle(4);
        chk("cnt_sat_d1", 32'(cnt_w[0]), 32'hFFFF);
        chk("cnt_sat_d3", 32'(cnt_w[1]), 32'hFFFF);
`endif

        // Latency: a single accept into an empty pipe.
        send(6'b001000, 6'd0, 11'h050, 1'b0);
        in_valid = 1'b0;
        first_v = '{0, 0};
        num_v   = '{0, 0};
        for (int c = 1; c <= 6; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (out_valid_w[i]) begin
                    if (first_v[i] == 0) first_v[i] = c;
                    num_v[i]++;
                end
            end
            step();
        end
        chk("latency_d1", 32'(first_v[0]), 32'd1);
        chk("latency_d3", 32'(first_v[1]), 32'd3);
        chk("valid_cycles_d1", 32'(num_v[0]), 32'd1);
        chk("valid_cycles_d3", 32'(num_v[1]), 32'd1);

        // Stall: downstream holds off for 5 cycles while input keeps streaming.
        out_ready = 1'b0;
        send(6'b001000, 6'd0, 11'h050, 1'b0); // ADDI
        chk("stall_in_ready_d1", 32'(in_ready_w[0]), 32'd0);
        send(6'b001100, 6'd0, 11'h150, 1'b0); // ANDI
        send(6'b001110, 6'd0, 11'h150, 1'b0); // XORI
        chk("stall_in_ready_d3", 32'(in_ready_w[1]), 32'd0);
        chk("stall_out_d3", 32'({out_valid_w[1], out_ctrl_w[1]}), 32'({1'b1, 12'h050}));
        send(6'b101011, 6'd0, 11'h014, 1'b0); // SW, refused
        send(6'b100011, 6'd0, 11'h252, 1'b0); // LW, refused
        chk("stall_out_d1", 32'({out_valid_w[0], out_ctrl_w[0]}), 32'({1'b1, 12'h050}));
        chk("stall_in_ready_both", 32'(in_ready_w), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(6);

        // Flush with an input offered in the same cycle.
        out_ready = 1'b0;
        send(6'b000010, 6'd0,      11'h001, 1'b0); // J
        send(6'b000000, 6'b001001, 11'h4E1, 1'b0); // JALR
        idle(1);
        chk("preflush_valid", 32'(out_valid_w), 32'd3);
        flush = 1'b1;
        send(6'b100011, 6'd0, 11'h252, 1'b0); // LW, must be dropped
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid_w), 32'd0);
        chk("flush_ctrl", 32'({out_ctrl_w[0], out_ctrl_w[1]}), 32'd0);
`ifdef DEC_ILLEGAL_CNT_EN
        chk("flush_cnt", 32'(cnt_w[1]), 32'hFFFF);
`endif
        out_ready = 1'b1;
        idle(5);

        // Reset while stalled with valid output.
        out_ready = 1'b0;
        send(6'b001000, 6'd0, 11'h050, 1'b0);
        idle(3);
        chk("prereset_valid", 32'(out_valid_w), 32'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midreset_valid", 32'(out_valid_w), 32'd0);
        chk("midreset_ctrl", 32'({out_ctrl_w[0], out_ctrl_w[1]}), 32'd0);
`ifdef DEC_ILLEGAL_CNT_EN
        chk("midreset_cnt", 32'({cnt_w[0], cnt_w[1]}), 32'd0);
`endif
        out_ready = 1'b1;
        send(6'b000000, 6'b100000, 11'h060, 1'b0); // ADD after reset
        idle(1);

        for (int k = 0; k < 50 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); k++) step();
        chk("drain_d1", 32'(exp_q[0].size()), 32'd0);
        chk("drain_d3", 32'(exp_q[1].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/maindec_pipe.md
Name: maindec_pipe

Overview:
- Parametrised successor to the single-cycle main decoder.
- Decodes the 6-bit opcode plus the R-type funct field into an extended 11-bit control word with an illegal-opcode flag.
- Carries the result through PIPE_DEPTH register stages with a valid/ready handshake, stall and flush.
- Sits between the IF/ID register and the ID/EX register of the pipelined MIPS core.

Parameters:
- CTRL_W, 11, control word width; must be ≥ 11; bits above 10 are driven 0.
- PIPE_DEPTH, 1, number of register stages, legal values 1..3.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  op/funct are valid this cycle.
- in_ready  out  1  the decoder accepts op/funct this cycle.
- op  in  6  instruction[31:26].
- funct  in  6  instruction[5:0]; used only when op = 000000.
- out_valid  out  1  out_ctrl and out_illegal are valid.
- out_ready  in  1  the downstream stage accepts the output.
- out_ctrl  out  CTRL_W  decoded control word.
- out_illegal  out  1  reserved/unsupported opcode.
- illegal_cnt  out  16  only present with DEC_ILLEGAL_CNT_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Control bits:
  - [0] Jump, [1] MemtoReg, [2] MemWrite, [3] Branch, [4] AluSrc, [5] RegDst.
  - [6] RegWrite, [7] Link, [8] ZeroExt, [9] MemRead, [10] JumpReg.
- Decode table (11-bit values, hex):
  - R-type 000000, funct not 001000/001001 -> 0x060.
  - R-type funct 001000 (JR) -> 0x401.
  - R-type funct 001001 (JALR) -> 0x4E1.
  - LW 100011 -> 0x252.
  - SW 101011 -> 0x014.
  - BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, REGIMM 000001 -> 0x008.
  - ADDI 001000, ADDIU 001001, SLTI 001010, SLTIU 001011 -> 0x050.
  - ANDI 001100, ORI 001101, XORI 001110, LUI 001111 -> 0x150.
  - J 000010 -> 0x001.
  - JAL 000011 -> 0x0C1.
  - Any other op -> 0x000 with illegal = 1. Illegal is 0 for every listed op.
- Pipeline structure:
  - Decode is combinational into stage 0.
  - Stage k holds {valid, ctrl, illegal}; the last stage drives the outputs.
- Stage advance: stage k loads from its upstream when it is empty or its downstream consumes it this cycle.
  - The last stage is consumed when out_valid && out_ready.
- in_ready = !stage0.valid || stage0 advances this cycle. Combinational from out_ready through the chain; there is no skid buffer.
- Accept is in_valid && in_ready && !flush.
- Timing:
  - With out_ready held 1, latency is PIPE_DEPTH cycles from accept to out_valid.
  - Throughput is 1 per cycle; no bubbles are inserted.
- Stall: while out_valid && !out_ready, out_ctrl, out_illegal and out_valid are held stable. Upstream stages fill, then in_ready drops.
- Output gating: out_ctrl = 0 and out_illegal = 0 whenever out_valid = 0.
- Flush:
  - Clears every stage's valid, ctrl and illegal on the next edge.
  - Takes priority over accept and advance in the same cycle; an input offered during flush is dropped.
  - in_ready may read 1 during flush.
- Reset (rst_n = 0 at an edge):
  - All valids = 0, out_ctrl = 0, out_illegal = 0.
  - Reset takes priority over flush and the handshake.
  - Reset mid-stream discards all in-flight entries.
- No combinational path from op/funct to the outputs.

Optional Feature:
- Macro DEC_ILLEGAL_CNT_EN.
- Defined:
  - illegal_cnt port present: a 16-bit counter, cleared to 0 by reset only.
  - Increments by 1 on each accepted entry whose decode is illegal.
  - Saturates at 0xFFFF. Flush does not decrement it or clear it.
- Undefined: no port, no counter logic; behaviour is otherwise identical.

Test Plan:
1. Reset, then stream LW, SW, BEQ, ORI, JAL, JR with PIPE_DEPTH = 1 and out_ready = 1 -> outputs 0x252, 0x014, 0x008, 0x150, 0x0C1, 0x401 on consecutive cycles, each 1 cycle after its accept.
2. PIPE_DEPTH = 3: accept ADDI at cycle 0 with out_ready = 1 -> out_valid and out_ctrl = 0x050 at cycle 3 only.
   - Hold out_ready = 0 for 5 cycles while streaming -> output stable at 0x050; in_ready goes 0 after 3 entries are held.
3. op = 111111 -> out_ctrl = 0x000, out_illegal = 1.
   - With DEC_ILLEGAL_CNT_EN: 3 such accepts -> illegal_cnt = 3.
   - Force the counter to 0xFFFF, then accept another illegal -> stays 0xFFFF.
4. Fill PIPE_DEPTH = 2 with J, JALR, then assert flush together with in_valid (LW) -> next cycle out_valid = 0, out_ctrl = 0, LW never appears, illegal_cnt unchanged.
5. Drive rst_n = 0 for one edge while out_valid = 1 and stalled -> next cycle out_valid = 0, out_ctrl = 0, illegal_cnt = 0.
   - First accept after reset is decoded normally (R-type add -> 0x060).
6. R-type with funct 001001 (JALR) vs funct 100000 (add) back-to-back -> 0x4E1 then 0x060; funct is ignored for op = 000010 (J -> 0x001).
